alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the team's 8-op scaled-arithmetic ALU.
- Same opcode set, generalised to WIDTH-bit signed operands, with a valid/ready handshake on both sides.
- Carries an address tag alongside each result and counts completed results.
- Sits between the operand register file reader and the writeback unit.

---
 rtl/alu_pipe_if.sv | 38 +++
 rtl/alu_pipe.sv | 144 ++++++++++++++
 tb/tb_alu_pipe.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [2:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out;
    logic [ADDR_W-1:0] out_addr;
`ifdef ALU_FLAGS_EN
    logic              out_zero;
    logic              out_neg;
`endif

    // The operand source and result sink live on the master side.
    modport master (
`ifdef ALU_FLAGS_EN
        input  out_zero, out_neg,
`endif
        output in_valid, a, b, sel, addr, out_ready,
        input  in_ready, out_valid, out, out_addr
    );

    modport slave (
`ifdef ALU_FLAGS_EN
        output out_zero, out_neg,
`endif
        input  in_valid, a, b, sel, addr, out_ready,
        output in_ready, out_valid, out, out_addr
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined scaled-arithmetic ALU with valid/ready on both sides.
// Optional zero/negative result flags are enabled with macro ALU_FLAGS_EN.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_pipe_if.slave        bus,
    output logic [CNT_W-1:0] done_cnt
);
    localparam int E = WIDTH + 4;

    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [WIDTH-1:0]  s1_b_q, s1_b_d;
    logic [2:0]        s1_sel_q, s1_sel_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
`ifdef ALU_FLAGS_EN
    logic              out_zero_q, out_zero_d;
    logic              out_neg_q, out_neg_d;
`endif

    logic adv;
    logic signed [E-1:0] ax, bx, sum, dif, t5, t6, t7;
    logic [WIDTH-1:0] res;

    // A single advance term stalls the whole pipe while the output is held.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sel_d   = s1_sel_q;
        s1_addr_d  = s1_addr_q;
        if (adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d    = bus.a;
                s1_b_d    = bus.b;
                s1_sel_d  = bus.sel;
                s1_addr_d = bus.addr;
            end
        end
    end

    // Four guard bits keep 6a+b and 3(a+b) exact before the final slice.
    always_comb begin
        ax  = {{4{s1_a_q[WIDTH-1]}}, s1_a_q};
        bx  = {{4{s1_b_q[WIDTH-1]}}, s1_b_q};
        sum = ax + bx;
        dif = ax - bx;
        t5  = (ax >>> 1) + (bx <<< 2);
        t6  = (sum <<< 1) + sum;
        t7  = (ax <<< 2) + (ax <<< 1) + bx;
        res = '0;
        case (s1_sel_q)
            3'd0: res = WIDTH'(sum >>> 1);
            3'd1: res = WIDTH'(dif >>> 1);
            3'd2: res = s1_a_q & s1_b_q;
            3'd3: res = s1_a_q | s1_b_q;
            3'd4: res = s1_a_q ^ s1_b_q;
            3'd5: res = WIDTH'(t5 >>> 3);
            3'd6: res = WIDTH'(t6 >>> 3);
            3'd7: res = WIDTH'(t7 >>> 3);
            default: res = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_addr_d  = out_addr_q;
`ifdef ALU_FLAGS_EN
        out_zero_d  = out_zero_q;
        out_neg_d   = out_neg_q;
`endif
        if (adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d      = res;
                out_addr_d = s1_addr_q;
`ifdef ALU_FLAGS_EN
                out_zero_d = (res == '0);
                out_neg_d  = res[WIDTH-1];
`endif
            end
        end
    end

    always_comb begin
        done_cnt_d = done_cnt_q;
        if (out_valid_q && bus.out_ready)
            done_cnt_d = done_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sel_q    <= '0;
            s1_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_addr_q  <= '0;
            done_cnt_q  <= '0;
`ifdef ALU_FLAGS_EN
            out_zero_q  <= 1'b0;
            out_neg_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_sel_q    <= s1_sel_d;
            s1_addr_q   <= s1_addr_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_addr_q  <= out_addr_d;
            done_cnt_q  <= done_cnt_d;
`ifdef ALU_FLAGS_EN
            out_zero_q  <= out_zero_d;
            out_neg_q   <= out_neg_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.out_addr  = out_addr_q;
    assign done_cnt      = done_cnt_q;
`ifdef ALU_FLAGS_EN
    assign bus.out_zero  = out_zero_q;
    assign bus.out_neg   = out_neg_q;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 8-bit and 12-bit instances sharing clock and reset.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] done_cnt;
    logic [15:0] done_cnt12;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8),  .ADDR_W(3)) bus ();
    alu_pipe_if #(.WIDTH(12), .ADDR_W(3)) bus12 ();

    alu_pipe #(.WIDTH(8), .ADDR_W(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .done_cnt(done_cnt));
    alu_pipe #(.WIDTH(12), .ADDR_W(3), .CNT_W(16)) u_dut12 (
        .clk(clk), .rst(rst), .bus(bus12), .done_cnt(done_cnt12));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s, input logic [2:0] ad);
        bus.in_valid = v;
        bus.a = a; bus.b = b; bus.sel = s; bus.addr = ad;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 8'h00 || bus.out_addr !== 3'd0 ||
            done_cnt !== 16'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got valid=%b out=%h addr=%0d cnt=%0d rdy=%b expected 0 00 0 0 1",
                     bus.out_valid, bus.out, bus.out_addr, done_cnt, bus.in_ready);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single;
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h10, 8'h20, 3'd0, 3'd5);
        step();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL single_latency1: got out_valid=%b expected 0", bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 8'h18 || bus.out_addr !== 3'd5) begin
            errors++;
            $display("FAIL single_out: got valid=%b out=%h addr=%0d expected 1 18 5",
                     bus.out_valid, bus.out, bus.out_addr);
        end
        step();
        checks++;
        if (done_cnt !== 16'd1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_cnt: got cnt=%0d valid=%b expected 1 0", done_cnt, bus.out_valid);
        end
    endtask

    // Four beats issued on consecutive cycles must emerge on consecutive cycles.
    task automatic run_stream(input string name, input logic [7:0] va [4], input logic [7:0] vb [4],
                              input logic [2:0] vs [4], input logic [7:0] ve [4]);
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, va[i], vb[i], vs[i], 3'(i));
            else       drive(1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
            step();
            if (i >= 1 && i <= 4) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out !== ve[i-1] || bus.out_addr !== 3'(i-1)) begin
                    errors++;
                    $display("FAIL %s[%0d]: got valid=%b out=%h addr=%0d expected 1 %h %0d",
                             name, i-1, bus.out_valid, bus.out, bus.out_addr, ve[i-1], i-1);
                end
            end
        end
        checks++;
        if (done_cnt !== 16'd4 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_cnt: got cnt=%0d valid=%b expected 4 0", name, done_cnt, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [2:0] vs [4];
        logic [7:0] ve [4];
        va = '{8'hFC, 8'h08, 8'h02, 8'h0A};
        vb = '{8'h04, 8'h06, 8'h02, 8'h04};
        vs = '{3'd1, 3'd5, 3'd6, 3'd7};
        ve = '{8'hFC, 8'h03, 8'h01, 8'h08};
        run_stream("b2b", va, vb, vs, ve);
    endtask

    task automatic test_boundary;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [2:0] vs [4];
        logic [7:0] ve [4];
        va = '{8'h80, 8'h7F, 8'h80, 8'h7F};
        vb = '{8'h80, 8'h7F, 8'h80, 8'h7F};
        vs = '{3'd0, 3'd6, 3'd5, 3'd7};
        ve = '{8'h80, 8'h5F, 8'hB8, 8'h6F};
        run_stream("bound", va, vb, vs, ve);
    endtask

    task automatic test_stall;
        logic [7:0] ta [4];
        logic [7:0] tb [4];
        logic [2:0] ts [4];
        logic [7:0] eo [4];
        int idx, oidx;
        logic prev_stall, hs_in, hs_out;
        logic [7:0] prev_out;
        logic [2:0] prev_addr;
        ta = '{8'h01, 8'hF0, 8'hFF, 8'hFE};
        tb = '{8'h10, 8'h3C, 8'h0F, 8'hFC};
        ts = '{3'd3, 3'd2, 3'd4, 3'd0};
        eo = '{8'h11, 8'h30, 8'hF0, 8'hFD};
        do_reset();
        idx = 0; oidx = 0; prev_stall = 1'b0; prev_out = '0; prev_addr = '0;
        for (int cyc = 0; cyc < 30 && oidx < 4; cyc++) begin
            if (idx < 4) drive(1'b1, ta[idx], tb[idx], ts[idx], 3'(idx + 1));
            else         drive(1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
            bus.out_ready = !(cyc >= 3 && cyc < 6);
            #1;
            if (prev_stall) begin
                checks++;
                if (bus.out !== prev_out || bus.out_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL stall_hold: got out=%h addr=%0d expected %h %0d",
                             bus.out, bus.out_addr, prev_out, prev_addr);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
                end
            end
            hs_in  = bus.in_valid && bus.in_ready;
            hs_out = bus.out_valid && bus.out_ready;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out = bus.out;
            prev_addr = bus.out_addr;
            if (hs_out) begin
                checks++;
                if (bus.out !== eo[oidx] || bus.out_addr !== 3'(oidx + 1)) begin
                    errors++;
                    $display("FAIL stall_out[%0d]: got out=%h addr=%0d expected %h %0d",
                             oidx, bus.out, bus.out_addr, eo[oidx], oidx + 1);
                end
                oidx++;
            end
            if (hs_in) idx++;
            step();
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (oidx != 4 || done_cnt !== 16'd4 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_count: got outs=%0d cnt=%0d valid=%b expected 4 4 0",
                     oidx, done_cnt, bus.out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h02, 3'd3, 3'd6);
        step();
        drive(1'b1, 8'h04, 8'h08, 3'd3, 3'd7);
        step();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || done_cnt !== 16'd0 || bus.out !== 8'h00 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset: got valid=%b cnt=%0d out=%h rdy=%b expected 0 0 00 1",
                     bus.out_valid, done_cnt, bus.out, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_stale[%0d]: got out_valid=%b expected 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_width12;
        do_reset();
        bus12.out_ready = 1'b1;
        bus12.in_valid = 1'b1; bus12.a = 12'h7FF; bus12.b = 12'h7FF; bus12.sel = 3'd6; bus12.addr = 3'd2;
        step();
        bus12.a = 12'h800; bus12.b = 12'h000; bus12.sel = 3'd7; bus12.addr = 3'd3;
        step();
        bus12.in_valid = 1'b0;
        checks++;
        if (bus12.out_valid !== 1'b1 || bus12.out !== 12'h5FF || bus12.out_addr !== 3'd2) begin
            errors++;
            $display("FAIL w12_sel6: got valid=%b out=%h addr=%0d expected 1 5ff 2",
                     bus12.out_valid, bus12.out, bus12.out_addr);
        end
        step();
        checks++;
        if (bus12.out_valid !== 1'b1 || bus12.out !== 12'hA00 || bus12.out_addr !== 3'd3) begin
            errors++;
            $display("FAIL w12_sel7: got valid=%b out=%h addr=%0d expected 1 a00 3",
                     bus12.out_valid, bus12.out, bus12.out_addr);
        end
    endtask

`ifdef ALU_FLAGS_EN
    task automatic test_flags;
        do_reset();
        bus.out_ready = 1'b1;
        drive(1'b1, 8'hA5, 8'hA5, 3'd4, 3'd1);
        step();
        drive(1'b1, 8'h00, 8'h02, 3'd1, 3'd2);
        step();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        checks++;
        if (bus.out !== 8'h00 || bus.out_zero !== 1'b1 || bus.out_neg !== 1'b0) begin
            errors++;
            $display("FAIL flags_zero: got out=%h z=%b n=%b expected 00 1 0", bus.out, bus.out_zero, bus.out_neg);
        end
        step();
        checks++;
        if (bus.out !== 8'hFF || bus.out_zero !== 1'b0 || bus.out_neg !== 1'b1) begin
            errors++;
            $display("FAIL flags_neg: got out=%h z=%b n=%b expected ff 0 1", bus.out, bus.out_zero, bus.out_neg);
        end
    endtask
`endif

    initial begin
        drive(1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        bus.out_ready = 1'b0;
        bus12.in_valid = 1'b0; bus12.a = '0; bus12.b = '0; bus12.sel = '0; bus12.addr = '0;
        bus12.out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_boundary();
        test_stall();
        test_reset_midstream();
        test_width12();
`ifdef ALU_FLAGS_EN
        test_flags();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
